// File: rtl/fft_frame_feeder_if.sv
// fft_frame_feeder_if
//   Streaming bundle between a sample source, the frame feeder and the FFT core.
//   Input side : in_data {re, im}, in_valid, in_ready (valid/ready, one complex sample).
//   Output side: out_data (LANES samples, lane l at [(l+1)*2*NBITS-1 : l*2*NBITS]),
//                out_valid, out_ready, out_sof, out_eof.
//   Modports   : slave  - the feeder's view (consumes samples, produces beats)
//                master - the environment's view (produces samples, consumes beats)
interface fft_frame_feeder_if #(
    parameter int NBITS = 10,
    parameter int LANES = 4
);
    logic [2*NBITS-1:0]       in_data;
    logic                     in_valid;
    logic                     in_ready;
    logic [LANES*2*NBITS-1:0] out_data;
    logic                     out_valid;
    logic                     out_ready;
    logic                     out_sof;
    logic                     out_eof;

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, out_sof, out_eof
    );

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, out_sof, out_eof
    );
endinterface

// File: rtl/fft_frame_feeder.sv
// fft_frame_feeder
//   Collects LANES consecutive complex samples into one parallel beat for the FFT
//   core, tags beats with start/end of an N-point frame and counts frames that
//   were fully accepted downstream. Data passes bit-exact.
//
//   Ports:
//     clk        rising-edge clock
//     rst        synchronous reset, active low
//     flush      (only with FFT_FRAME_FEEDER_FLUSH_EN) pulse: zero-pad the current
//                partial frame up to its end-of-frame beat
//     bus        fft_frame_feeder_if.slave (sample in, beat out, sof/eof)
//     frame_cnt  completed-frame counter, wraps modulo 2^FCNT_W
//
//   Build option: define FFT_FRAME_FEEDER_FLUSH_EN to add the flush port and the
//   PAD state. Without it a partial frame simply waits for more input.
//
//   State | meaning            (flush build only)
//   ------+------------------------------------------------------------
//   COLLECT | normal operation, samples come from the input stream
//   PAD     | input blocked, a zero sample is inserted every free cycle
//           | until the end-of-frame beat is loaded
module fft_frame_feeder #(
    parameter int NBITS  = 10,
    parameter int LANES  = 4,
    parameter int N      = 128,
    parameter int FCNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
`ifdef FFT_FRAME_FEEDER_FLUSH_EN
    input  logic               flush,
`endif
    fft_frame_feeder_if.slave  bus,
    output logic [FCNT_W-1:0]  frame_cnt
);
    localparam int W  = 2*NBITS;
    localparam int NB = N/LANES;
    localparam int LW = $clog2(LANES);
    localparam int BW = $clog2(NB);
    localparam logic [LW-1:0] LAST_LANE = LW'(LANES-1);
    localparam logic [BW-1:0] LAST_BEAT = BW'(NB-1);

    logic [LW-1:0]      lcnt;
    logic [BW-1:0]      bcnt;
    logic [LW-1:0]      lcnt_nxt;
    logic [BW-1:0]      bcnt_nxt;
    logic [W-1:0]       collect [LANES-1];
    logic [LANES*W-1:0] out_data_q;
    logic               out_valid_q;
    logic               out_sof_q;
    logic               out_eof_q;

    logic               pad;
    logic               stall;
    logic               wr;
    logic               load;
    logic               handshake;
    logic [W-1:0]       sample;
    logic [LANES*W-1:0] beat;

    // Only the completing sample of a beat needs the output register free.
    assign stall     = (lcnt == LAST_LANE) && out_valid_q && !bus.out_ready;
    assign bus.in_ready = rst && !pad && !stall;
    assign wr        = rst && !stall && (pad || bus.in_valid);
    assign sample    = pad ? '0 : bus.in_data;
    assign load      = wr && (lcnt == LAST_LANE);
    assign handshake = out_valid_q && bus.out_ready;

    assign lcnt_nxt = wr ? lcnt + LW'(1) : lcnt;
    assign bcnt_nxt = !load ? bcnt : ((bcnt == LAST_BEAT) ? '0 : bcnt + BW'(1));

    always_comb begin
        beat = '0;
        for (int l = 0; l < LANES-1; l++) begin
            beat[l*W +: W] = collect[l];
        end
        beat[(LANES-1)*W +: W] = sample;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            lcnt        <= '0;
            bcnt        <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_sof_q   <= 1'b0;
            out_eof_q   <= 1'b0;
            frame_cnt   <= '0;
            for (int l = 0; l < LANES-1; l++) begin
                collect[l] <= '0;
            end
        end else begin
            lcnt <= lcnt_nxt;
            bcnt <= bcnt_nxt;
            if (wr) begin
                for (int l = 0; l < LANES-1; l++) begin
                    if (lcnt == LW'(l)) begin
                        collect[l] <= sample;
                    end
                end
            end
            // A load on the handshake edge replaces the old beat with no bubble.
            if (load) begin
                out_data_q  <= beat;
                out_valid_q <= 1'b1;
                out_sof_q   <= (bcnt == '0);
                out_eof_q   <= (bcnt == LAST_BEAT);
            end else if (handshake) begin
                out_valid_q <= 1'b0;
                out_sof_q   <= 1'b0;
                out_eof_q   <= 1'b0;
            end
            if (handshake && out_eof_q) begin
                frame_cnt <= frame_cnt + FCNT_W'(1);
            end
        end
    end

`ifdef FFT_FRAME_FEEDER_FLUSH_EN
    localparam logic [0:0] ST_COLLECT = 1'b0;
    localparam logic [0:0] ST_PAD     = 1'b1;

    logic [0:0] state;

    assign pad = (state == ST_PAD);

    // The boundary test uses the post-accept counters so a flush arriving with the
    // frame's last sample does not pad a whole new frame.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_COLLECT;
        end else begin
            case (state)
                ST_COLLECT: begin
                    if (flush && (lcnt_nxt != '0 || bcnt_nxt != '0)) begin
                        state <= ST_PAD;
                    end
                end
                default: begin
                    if (load && bcnt == LAST_BEAT) begin
                        state <= ST_COLLECT;
                    end
                end
            endcase
        end
    end
`else
    assign pad = 1'b0;
`endif

    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_sof   = out_sof_q;
    assign bus.out_eof   = out_eof_q;
endmodule

// File: tb/tb_fft_frame_feeder.sv
// tb_fft_frame_feeder
//   Bench for fft_frame_feeder. A queue-based reference tracks the samples taken,
//   the beat held at the output and the frame count; one negedge process compares
//   the DUT against it every cycle. Directed literal checks pin the reference.
//   The frame counter is built 4 bits wide so its wrap is reached in a short run.
module tb_fft_frame_feeder;
    localparam int NBITS = 10;
    localparam int LANES = 4;
    localparam int N     = 128;
    localparam int FW    = 4;
    localparam int W     = 2*NBITS;
    localparam int NB    = N/LANES;
    localparam int BWID  = LANES*W;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [FW-1:0] frame_cnt;
`ifdef FFT_FRAME_FEEDER_FLUSH_EN
    logic flush = 1'b0;
`endif

    always #5 clk = ~clk;

    fft_frame_feeder_if #(.NBITS(NBITS), .LANES(LANES)) bus ();

    fft_frame_feeder #(.NBITS(NBITS), .LANES(LANES), .N(N), .FCNT_W(FW)) dut (
        .clk       (clk),
        .rst       (rst),
`ifdef FFT_FRAME_FEEDER_FLUSH_EN
        .flush     (flush),
`endif
        .bus       (bus),
        .frame_cnt (frame_cnt)
    );

    int vectors    = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [BWID-1:0] act, input logic [BWID-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: dut=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [W-1:0]    col [$];
    int              m_bn = 0;
    logic            m_ov = 1'b0, m_sof = 1'b0, m_eof = 1'b0, pad_m = 1'b0;
    logic [BWID-1:0] m_od = '0;
    logic [FW-1:0]   m_fc = '0;
    bit              chk_en = 0;
    logic            m_stall, m_rdy, m_wr, m_hs, m_pad_pre;

    logic [BWID-1:0] got_d [$];
    bit              got_sof [$];
    bit              got_eof [$];

    always @(negedge clk) begin
        m_stall = (col.size() == LANES-1) && m_ov && !bus.out_ready;
        m_rdy   = rst && !pad_m && !m_stall;
        if (chk_en) begin
            check("in_ready",  BWID'(bus.in_ready),  BWID'(m_rdy));
            check("out_valid", BWID'(bus.out_valid), BWID'(m_ov));
            check("out_data",  bus.out_data,         m_od);
            check("frame_cnt", BWID'(frame_cnt),     BWID'(m_fc));
            if (m_ov) begin
                check("out_sof", BWID'(bus.out_sof), BWID'(m_sof));
                check("out_eof", BWID'(bus.out_eof), BWID'(m_eof));
            end
        end
        if (rst && bus.out_valid && bus.out_ready) begin
            got_d.push_back(bus.out_data);
            got_sof.push_back(bus.out_sof);
            got_eof.push_back(bus.out_eof);
        end
        if (!rst) begin
            col.delete();
            m_bn  = 0;
            m_ov  = 1'b0;
            m_sof = 1'b0;
            m_eof = 1'b0;
            m_od  = '0;
            m_fc  = '0;
            pad_m = 1'b0;
        end else begin
            m_pad_pre = pad_m;
            m_hs = m_ov && bus.out_ready;
            if (m_hs && m_eof) m_fc = m_fc + 1'b1;
            if (m_hs) m_ov = 1'b0;
            m_wr = !m_stall && (pad_m || bus.in_valid);
            if (m_wr) begin
                col.push_back(pad_m ? '0 : bus.in_data);
                if (col.size() == LANES) begin
                    for (int l = 0; l < LANES; l++) m_od[l*W +: W] = col[l];
                    m_ov  = 1'b1;
                    m_sof = (m_bn == 0);
                    m_eof = (m_bn == NB-1);
                    if (m_eof) pad_m = 1'b0;
                    m_bn = (m_bn + 1) % NB;
                    col.delete();
                end
            end
`ifdef FFT_FRAME_FEEDER_FLUSH_EN
            if (flush && !m_pad_pre && (col.size() != 0 || m_bn != 0)) pad_m = 1'b1;
`endif
        end
    end

    // ---------------- downstream ready driver ----------------
    int rdy_mode  = 0;
    bit stall_arm = 0;
    bit stall_done = 0;
    int hold_lo   = 0;

    always @(posedge clk) begin
        #1;
        if (stall_arm && !stall_done && bus.out_valid &&
            bus.out_data[W-1:NBITS] == NBITS'(16)) begin
            stall_done = 1;
            hold_lo = 10;
        end
        if (hold_lo > 0) begin
            bus.out_ready = 1'b0;
            hold_lo--;
        end else begin
            bus.out_ready = (rdy_mode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
        end
    end

    // ---------------- stimulus helpers ----------------
    int cur_idx = 0;
    int first_stall = -1;

    function automatic logic [W-1:0] ramp(input int i);
        logic [NBITS-1:0] re, im;
        re = NBITS'(i);
        im = NBITS'(-i);
        return {re, im};
    endfunction

    function automatic logic [BWID-1:0] ramp_beat(input int b);
        logic [BWID-1:0] v;
        for (int l = 0; l < LANES; l++) v[l*W +: W] = ramp(b*LANES + l);
        return v;
    endfunction

    task automatic send(input logic [W-1:0] d, input int gap);
        bit done = 0;
        for (int g = 0; g < gap; g++) begin
            bus.in_valid = 1'b0;
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        for (int t = 0; t < 100 && !done; t++) begin
            @(negedge clk);
            if (bus.in_ready) done = 1;
            else if (first_stall < 0) first_stall = cur_idx;
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        if (!done) begin
            vectors++;
            miscompares++;
            $display("FAIL send_timeout: sample %0d not accepted, required accept within 100 cycles", cur_idx);
        end
    endtask

    task automatic ramp_frame(input int nsamp, input int gap);
        for (int i = 0; i < nsamp; i++) begin
            cur_idx = i;
            send(ramp(i), gap);
        end
    endtask

    task automatic drain();
        bit idle = 0;
        for (int t = 0; t < 400 && !idle; t++) begin
            @(negedge clk);
            if (!bus.out_valid) idle = 1;
        end
        if (!idle) begin
            vectors++;
            miscompares++;
            $display("FAIL drain_timeout: out_valid=1, required 0 within 400 cycles");
        end
        @(posedge clk); #1;
    endtask

    task automatic clear_log();
        got_d.delete();
        got_sof.delete();
        got_eof.delete();
    endtask

    task automatic check_ramp_frame(input string name);
        bit ok = 1;
        check({name, "_beats"}, BWID'(got_d.size()), BWID'(NB));
        for (int b = 0; b < NB && b < got_d.size(); b++) begin
            if (got_d[b] !== ramp_beat(b) || got_sof[b] != (b == 0) || got_eof[b] != (b == NB-1))
                ok = 0;
        end
        check({name, "_content"}, BWID'(ok), BWID'(1));
    endtask

    task automatic do_reset();
        bus.in_valid = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("rst_out_valid", BWID'(bus.out_valid), '0);
        check("rst_out_data",  bus.out_data,         '0);
        check("rst_frame_cnt", BWID'(frame_cnt),     '0);
        check("rst_in_ready",  BWID'(bus.in_ready),  BWID'(1));
        @(posedge clk); #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk_en = 1;
        check("init_out_valid", BWID'(bus.out_valid), '0);
        check("init_out_data",  bus.out_data,         '0);
        check("init_in_ready",  BWID'(bus.in_ready),  BWID'(1));
        @(posedge clk); #1;

        // 1: one ramp frame, back-to-back, always ready
        rdy_mode = 0;
        clear_log();
        ramp_frame(N, 0);
        drain();
        check_ramp_frame("ramp");
        if (got_d.size() > 0) begin
            check("beat0_literal", got_d[0], 80'h00FFD00BFE007FF00000);
            check("beat0_sof", BWID'(got_sof[0]), BWID'(1));
        end
        if (got_d.size() == NB) begin
            check("beat31_lane0_re", BWID'(got_d[NB-1][W-1:NBITS]), BWID'(124));
            check("beat31_eof", BWID'(got_eof[NB-1]), BWID'(1));
        end
        check("frame_cnt_1", BWID'(frame_cnt), BWID'(1));

        // 2: downstream stalls 10 cycles on the beat starting at sample 16
        clear_log();
        first_stall = -1;
        stall_arm = 1;
        ramp_frame(N, 0);
        drain();
        stall_arm = 0;
        check_ramp_frame("stall");
        check("first_stall_sample", BWID'(first_stall), BWID'(23));
        check("frame_cnt_2", BWID'(frame_cnt), BWID'(2));

        // 3: in_valid toggling
        clear_log();
        ramp_frame(N, 1);
        drain();
        check_ramp_frame("gaps");
        check("frame_cnt_3", BWID'(frame_cnt), BWID'(3));

        // 4: reset mid-frame, then a fresh frame with random downstream ready
        ramp_frame(70, 0);
        do_reset();
        clear_log();
        rdy_mode = 1;
        ramp_frame(N, 0);
        drain();
        rdy_mode = 0;
        drain();
        check_ramp_frame("post_reset");

        // 5: 16 more random frames -> 17 since reset, 4-bit counter wraps to 1
        rdy_mode = 1;
        for (int f = 0; f < 16; f++) begin
            for (int i = 0; i < N; i++) begin
                cur_idx = i;
                send(W'($urandom), $urandom_range(0, 2));
            end
        end
        rdy_mode = 0;
        drain();
        drain();
        check("frame_cnt_wrap", BWID'(frame_cnt), BWID'(1));

`ifdef FFT_FRAME_FEEDER_FLUSH_EN
        // 6: flush after 50 samples pads the frame with zeros
        do_reset();
        clear_log();
        ramp_frame(50, 0);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        check("pad_in_ready", BWID'(bus.in_ready), '0);
        for (int t = 0; t < 400 && got_d.size() < NB; t++) @(negedge clk);
        check("pad_beats", BWID'(got_d.size()), BWID'(NB));
        if (got_d.size() == NB) begin
            check("pad_beat12", got_d[12], {{(2*W){1'b0}}, ramp(49), ramp(48)});
            check("pad_beat13", got_d[13], '0);
            check("pad_beat31", got_d[NB-1], '0);
            check("pad_eof", BWID'(got_eof[NB-1]), BWID'(1));
        end
        drain();
        check("pad_frame_cnt", BWID'(frame_cnt), BWID'(1));
        @(negedge clk);
        check("pad_in_ready_back", BWID'(bus.in_ready), BWID'(1));
        @(posedge clk); #1;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/fft_frame_feeder.md
Name: fft_frame_feeder

Overview:
- Synthesizable front end for the parallel FFT core. Replaces file-driven bench stimulus with a real streaming interface.
- Accepts one complex sample per cycle over a valid/ready stream.
- Groups LANES consecutive samples into one parallel beat for the core's lane inputs.
- Tags beats with start-of-frame and end-of-frame for an N-point frame, and counts completed frames.

Parameters:
- NBITS, 10: bits per real/imag component; sample word is {re, im}, re in upper NBITS.
- LANES, 4: complex samples per output beat; power of 2, >=2.
- N, 128: FFT points per frame; N % LANES == 0; N/LANES >= 2.
- FCNT_W, 16: width of the completed-frame counter.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-low; sampled on the rising edge of clk.
- in_data  in  2*NBITS  complex input sample.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  feeder accepts a sample this cycle.
- out_data  out  LANES*2*NBITS  parallel beat; lane l at bits [(l+1)*2*NBITS-1 : l*2*NBITS].
- out_valid  out  1  out_data holds a beat.
- out_ready  in  1  downstream accepts the beat.
- out_sof  out  1  beat is the first of a frame; qualified by out_valid.
- out_eof  out  1  beat is the last of a frame; qualified by out_valid.
- frame_cnt  out  FCNT_W  number of frames fully accepted downstream; wraps modulo 2^FCNT_W.

Behaviour:
- Reset (rst==0 at a clk edge) clears everything:
  - out_valid=0, out_sof=0, out_eof=0, out_data=0, frame_cnt=0.
  - Lane counter and beat counter = 0; collect buffer cleared.
  - in_ready=0 while rst==0, and =1 in the first cycle after release.
- Reset mid-frame discards all partial and pending data. The next accepted sample is lane 0 of beat 0 of a new frame.
- Input accept: in_valid && in_ready. The accepted sample is written to collect lane lcnt, then lcnt increments modulo LANES.
- in_ready = 0 only when lcnt==LANES-1 && out_valid && !out_ready; otherwise 1. in_ready is combinational from registered state and out_ready.
- Beat load occurs when the lane-(LANES-1) sample is accepted:
  - The complete beat (collect lanes 0..LANES-2 plus the incoming sample) is registered into out_data in the same edge.
  - out_valid=1; out_sof=(bcnt==0); out_eof=(bcnt==N/LANES-1).
  - bcnt increments modulo N/LANES.
- Latency: last sample of a beat accepted at edge k -> out_valid=1 after edge k, i.e. 1 cycle.
- Output hold: while out_valid && !out_ready, out_data, out_sof and out_eof stay stable.
- Output handshake: out_valid && out_ready.
  - If no new beat loads on the same edge, out_valid clears.
  - A simultaneous handshake and new beat load is legal: the new beat replaces the old one with no bubble.
- frame_cnt increments on a handshake whose out_eof==1.
- Throughput: sustained 1 sample/cycle in, 1 beat per LANES cycles out. No stall occurs unless downstream holds out_ready low for LANES or more cycles.
- Lanes 0..LANES-2 accept even while the output register is occupied; only the completing sample stalls.
- in_valid low produces gaps only; the lane and beat counters freeze.
- Sample ordering matches the core: sample 4m+0..3 maps to fftIn0_up, fftIn0_down, fftIn1_up, fftIn1_down for LANES=4.
- No arithmetic is performed; data is passed bit-exact.

Optional Feature:
- Macro: FFT_FRAME_FEEDER_FLUSH_EN.
- With the macro, add port flush (in, 1, single-cycle pulse).
  - If flush is seen while lcnt!=0 or bcnt!=0, the block enters a PAD state.
  - In PAD: in_ready=0, and a zero sample is inserted into the next lane each cycle. Normal load and stall rules apply.
  - PAD ends at the edge that loads the out_eof beat; the block then returns to IDLE/COLLECT.
  - flush at a frame boundary (lcnt==0 && bcnt==0) is ignored.
  - flush during PAD is ignored.
  - If flush coincides with an accepted sample, that sample is taken first and padding starts with the next lane.
  - Reset overrides PAD.
- Without the macro: no flush port, no PAD state; a partial frame waits indefinitely for input.

Test Plan:
- Reset then 128 samples with re=i, im=-i, out_ready=1 -> 32 beats:
  - beat 0: lanes {0,1,2,3}, out_sof=1; beat 31: lanes {124..127}, out_eof=1.
  - each beat appears 1 cycle after its 4th sample; frame_cnt=1.
- out_ready held 0 for 10 cycles during beat 5 -> out_data/out_sof/out_eof stable; in_ready drops only at sample 23; no sample lost or duplicated.
- in_valid toggled 1,0,1,0 for one frame -> same 32 beats as the first case, only spaced wider.
- rst=0 for 1 cycle after 70 samples, then 128 fresh samples -> all outputs 0 during reset; next beat has out_sof=1 and carries the fresh samples 0..3.
- 2^16+1 frames back-to-back -> frame_cnt wraps to 1.
- FFT_FRAME_FEEDER_FLUSH_EN: flush after 50 samples -> in_ready=0; beats 12 and 13 hold lanes {48,49,0,0} and {0,0,0,0}; zero beats continue through beat 31 with out_eof=1; frame_cnt=1; in_ready returns to 1.
